// File: rtl/spi_slave_ctrl.sv
// Control-port engine for a 3/4-wire SPI: instruction decode, register-bank strobes and encoder readback hand-off.
// state    | meaning
// IDLE     | waiting for chip select to fall
// INSTR    | shifting the 16-bit R/W, W1:W0, address instruction
// WR       | shifting write bytes, one strobe per completed byte
// RD       | feeding read bytes to the encoder, one read strobe per byte
// DONE     | byte count exhausted, waiting for chip select to rise
module spi_slave_ctrl #(
   parameter int ADDR_W      = 13,
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              I_clk,
   input  logic              I_rst,
   input  logic              I_sclk_pin,
   input  logic              I_csb_pin,
   input  logic              I_sdi_pin,
   input  logic [DATA_W-1:0] I_reg_rdata,
   output logic [ADDR_W-1:0] O_reg_addr,
   output logic [DATA_W-1:0] O_reg_wdata,
   output logic              O_reg_wr,
   output logic              O_reg_rd,
   output logic              O_enc_enable,
   output logic              O_enc_latch,
   output logic [DATA_W-1:0] O_enc_data,
   output logic              O_busy
);

   localparam int INSTR_W = ADDR_W + 3;
   localparam int CNT_W   = $clog2(INSTR_W) + 1;
   localparam logic [CNT_W-1:0]  INSTR_LAST = CNT_W'(INSTR_W - 1);
   localparam logic [CNT_W-1:0]  BYTE_LAST  = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

   typedef enum logic [2:0] {ST_IDLE, ST_INSTR, ST_WR, ST_RD, ST_DONE} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_q, csb_sync_q, sdi_sync_q, flush_q;
   logic                   sclk_prev_q, csb_prev_q, armed_q;
   logic                   sclk_s, csb_s, sdi_s;
   logic                   sclk_rise, sclk_fall, csb_rise, csb_fall;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [INSTR_W-1:0]  shift_q, shift_d, shift_in;
   logic [1:0]          byte_left_q, byte_left_d;
   logic                stream_q, stream_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d, enc_data_q, enc_data_d;
   logic                wr_q, wr_d, rd_q, rd_d, load_q, load_d;
   logic                enc_en_q, enc_en_d, enc_latch_q, enc_latch_d;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign csb_s  = csb_sync_q[SYNC_STAGES-1];
   assign sdi_s  = sdi_sync_q[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign csb_rise  = csb_s & ~csb_prev_q;
   // Only arm on a genuinely high CSB so a select held low across reset is not decoded mid-stream.
   assign csb_fall  = armed_q & ~csb_s & csb_prev_q;

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         sclk_sync_q <= '1;
         csb_sync_q  <= '1;
         sdi_sync_q  <= '1;
         flush_q     <= '0;
         sclk_prev_q <= 1'b1;
         csb_prev_q  <= 1'b1;
         armed_q     <= 1'b0;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         byte_left_q <= '0;
         stream_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wr_q        <= 1'b0;
         rd_q        <= 1'b0;
         load_q      <= 1'b0;
         enc_en_q    <= 1'b0;
         enc_latch_q <= 1'b0;
         enc_data_q  <= '0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], I_sclk_pin};
         csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], I_csb_pin};
         sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], I_sdi_pin};
         flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
         sclk_prev_q <= sclk_s;
         csb_prev_q  <= csb_s;
         armed_q     <= armed_q | (flush_q[SYNC_STAGES-1] & csb_s);
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         byte_left_q <= byte_left_d;
         stream_q    <= stream_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         load_q      <= load_d;
         enc_en_q    <= enc_en_d;
         enc_latch_q <= enc_latch_d;
         enc_data_q  <= enc_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      byte_left_d = byte_left_q;
      stream_d    = stream_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wr_d        = 1'b0;
      rd_d        = 1'b0;
      load_d      = 1'b0;
      enc_en_d    = enc_en_q;
      enc_latch_d = enc_latch_q;
      enc_data_d  = enc_data_q;
      shift_in    = {shift_q[INSTR_W-2:0], sdi_s};

      if (wr_q)
         addr_d = addr_q - ADDR_ONE;
      if (enc_latch_q && sclk_fall)
         enc_latch_d = 1'b0;
      if (rd_q)
         load_d = 1'b1;
      // Read data is valid the cycle after the strobe; hold latch until the encoder sees a falling edge.
      if (load_q && state_q == ST_RD) begin
         enc_data_d  = I_reg_rdata;
         enc_latch_d = 1'b1;
         enc_en_d    = 1'b1;
      end

      if (csb_rise) begin
         state_d     = ST_IDLE;
         bit_cnt_d   = '0;
         byte_left_d = '0;
         stream_d    = 1'b0;
         load_d      = 1'b0;
         enc_en_d    = 1'b0;
         enc_latch_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (csb_fall) begin
                  state_d   = ST_INSTR;
                  bit_cnt_d = '0;
               end
            end
            ST_INSTR: begin
               if (sclk_rise) begin
                  shift_d   = shift_in;
                  bit_cnt_d = bit_cnt_q + CNT_ONE;
                  if (bit_cnt_q == INSTR_LAST) begin
                     bit_cnt_d   = '0;
                     addr_d      = shift_in[ADDR_W-1:0];
                     byte_left_d = shift_in[ADDR_W+1:ADDR_W];
                     stream_d    = &shift_in[ADDR_W+1:ADDR_W];
                     if (shift_in[ADDR_W+2]) begin
                        state_d = ST_RD;
                        rd_d    = 1'b1;
                     end else begin
                        state_d = ST_WR;
                     end
                  end
               end
            end
            ST_WR: begin
               if (sclk_rise) begin
                  shift_d   = shift_in;
                  bit_cnt_d = bit_cnt_q + CNT_ONE;
                  if (bit_cnt_q == BYTE_LAST) begin
                     bit_cnt_d = '0;
                     wdata_d   = shift_in[DATA_W-1:0];
                     wr_d      = 1'b1;
                     if (!stream_q && byte_left_q == 2'd0)
                        state_d = ST_DONE;
                     else if (!stream_q)
                        byte_left_d = byte_left_q - 2'd1;
                  end
               end
            end
            ST_RD: begin
               if (sclk_rise) begin
                  bit_cnt_d = bit_cnt_q + CNT_ONE;
                  if (bit_cnt_q == BYTE_LAST) begin
                     bit_cnt_d = '0;
                     if (!stream_q && byte_left_q == 2'd0) begin
                        state_d = ST_DONE;
                     end else begin
                        if (!stream_q)
                           byte_left_d = byte_left_q - 2'd1;
                        addr_d = addr_q - ADDR_ONE;
                        rd_d   = 1'b1;
                     end
                  end
               end
            end
            ST_DONE: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign O_reg_addr   = addr_q;
   assign O_reg_wdata  = wdata_q;
   assign O_reg_wr     = wr_q;
   assign O_reg_rd     = rd_q;
   assign O_enc_enable = enc_en_q;
   assign O_enc_latch  = enc_latch_q;
   assign O_enc_data   = enc_data_q;
   assign O_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: SPI master driver, register-bank and encoder models, write/read scoreboards.
module tb_spi_slave_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sclk = 1'b1;
   logic        csb = 1'b1;
   logic        sdi = 1'b0;
   logic [7:0]  rdata = 8'h00;
   logic [12:0] reg_addr;
   logic [7:0]  reg_wdata, enc_data;
   logic        reg_wr, reg_rd, enc_enable, enc_latch, busy;

   int n_cmp = 0;
   int n_bad = 0;
   int overlap = 0;

   logic [12:0] wr_addr_q[$];
   logic [7:0]  wr_data_q[$];
   logic [12:0] rd_addr_q[$];
   logic [7:0]  tx_bytes[4];
   logic [7:0]  rx_bytes[4];
   logic [7:0]  enc_sr = 8'h00;

   spi_slave_ctrl dut (
      .I_clk        (clk),
      .I_rst        (rst),
      .I_sclk_pin   (sclk),
      .I_csb_pin    (csb),
      .I_sdi_pin    (sdi),
      .I_reg_rdata  (rdata),
      .O_reg_addr   (reg_addr),
      .O_reg_wdata  (reg_wdata),
      .O_reg_wr     (reg_wr),
      .O_reg_rd     (reg_rd),
      .O_enc_enable (enc_enable),
      .O_enc_latch  (enc_latch),
      .O_enc_data   (enc_data),
      .O_busy       (busy)
   );

   always #5 clk = ~clk;

   // Register bank: answers a read strobe with data valid through the following cycle.
   always @(negedge clk) begin
      if (reg_wr) begin
         wr_addr_q.push_back(reg_addr);
         wr_data_q.push_back(reg_wdata);
      end
      if (reg_rd) begin
         rd_addr_q.push_back(reg_addr);
         rdata = (reg_addr == 13'h005) ? 8'h3C : (reg_addr == 13'h004) ? 8'hC3 : 8'h00;
      end
      if (reg_wr && reg_rd)
         overlap++;
   end

   // Encoder: loads on an SCLK falling edge while latched, otherwise shifts MSB first.
   always @(negedge sclk) begin
      if (enc_latch)
         enc_sr = enc_data;
      else
         enc_sr = {enc_sr[6:0], 1'b0};
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic half();
      repeat (8) @(negedge clk);
   endtask

   task automatic clear_sb();
      wr_addr_q.delete();
      wr_data_q.delete();
      rd_addr_q.delete();
      for (int i = 0; i < 4; i++) rx_bytes[i] = 8'h00;
   endtask

   task automatic spi_xfer(input logic [15:0] instr, input int nbits, input bit hold_csb);
      @(negedge clk);
      csb = 1'b0;
      half();
      for (int i = 15; i >= 0; i--) begin
         sclk = 1'b0;
         sdi  = instr[i];
         half();
         sclk = 1'b1;
         half();
      end
      for (int b = 0; b < nbits; b++) begin
         sclk = 1'b0;
         sdi  = tx_bytes[b / 8][7 - (b % 8)];
         half();
         rx_bytes[b / 8][7 - (b % 8)] = enc_sr[7];
         sclk = 1'b1;
         half();
      end
      if (!hold_csb) begin
         csb = 1'b1;
         repeat (16) @(negedge clk);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {30'd0, busy, reg_wr, reg_rd, enc_enable, enc_latch, enc_data, reg_addr, reg_wdata};
   endfunction

   initial begin
      repeat (4) @(negedge clk);
      chk("reset_outputs", all_outs(), 64'd0);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("idle_busy", busy, 1'b0);

      // single-byte write
      clear_sb();
      tx_bytes[0] = 8'hA5;
      spi_xfer(16'h0014, 8, 1'b1);
      repeat (4) @(negedge clk);
      chk("w1_busy_done", busy, 1'b1);
      csb = 1'b1;
      repeat (16) @(negedge clk);
      chk("w1_count", wr_addr_q.size(), 1);
      chk("w1_addr", wr_addr_q[0], 13'h014);
      chk("w1_data", wr_data_q[0], 8'hA5);
      chk("w1_busy_idle", busy, 1'b0);

      // three-byte write plus an ignored fourth byte
      clear_sb();
      tx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
      spi_xfer(16'h40FF, 32, 1'b0);
      chk("w3_count", wr_addr_q.size(), 3);
      chk("w3_addr0", wr_addr_q[0], 13'h0FF);
      chk("w3_data0", wr_data_q[0], 8'h11);
      chk("w3_addr1", wr_addr_q[1], 13'h0FE);
      chk("w3_data1", wr_data_q[1], 8'h22);
      chk("w3_addr2", wr_addr_q[2], 13'h0FD);
      chk("w3_data2", wr_data_q[2], 8'h33);

      // two-byte read through the encoder
      clear_sb();
      tx_bytes = '{8'h00, 8'h00, 8'h00, 8'h00};
      spi_xfer(16'hA005, 16, 1'b1);
      repeat (8) @(negedge clk);
      chk("rd_count", rd_addr_q.size(), 2);
      chk("rd_addr0", rd_addr_q[0], 13'h005);
      chk("rd_addr1", rd_addr_q[1], 13'h004);
      chk("rd_sdo0", rx_bytes[0], 8'h3C);
      chk("rd_sdo1", rx_bytes[1], 8'hC3);
      chk("rd_enable_held", enc_enable, 1'b1);
      chk("rd_busy_done", busy, 1'b1);
      csb = 1'b1;
      repeat (16) @(negedge clk);
      chk("rd_enable_off", enc_enable, 1'b0);
      chk("rd_latch_off", enc_latch, 1'b0);
      chk("rd_busy_idle", busy, 1'b0);
      chk("rd_no_write", wr_addr_q.size(), 0);

      // streaming write across the address wrap
      clear_sb();
      tx_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
      spi_xfer(16'h6001, 32, 1'b0);
      chk("st_count", wr_addr_q.size(), 4);
      chk("st_addr0", wr_addr_q[0], 13'h0001);
      chk("st_addr1", wr_addr_q[1], 13'h0000);
      chk("st_addr2", wr_addr_q[2], 13'h1FFF);
      chk("st_addr3", wr_addr_q[3], 13'h1FFE);
      chk("st_data3", wr_data_q[3], 8'h04);

      // abort after five data bits, then a clean write
      clear_sb();
      tx_bytes[0] = 8'hFF;
      spi_xfer(16'h0014, 5, 1'b0);
      chk("ab_no_write", wr_addr_q.size(), 0);
      chk("ab_busy", busy, 1'b0);
      chk("ab_enable", enc_enable, 1'b0);
      tx_bytes[0] = 8'h5A;
      spi_xfer(16'h0033, 8, 1'b0);
      chk("ab_next_count", wr_addr_q.size(), 1);
      chk("ab_next_addr", wr_addr_q[0], 13'h033);
      chk("ab_next_data", wr_data_q[0], 8'h5A);

      // reset in the middle of a read
      clear_sb();
      spi_xfer(16'hA005, 4, 1'b1);
      chk("mr_enable_before", enc_enable, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("mr_outputs_zero", all_outs(), 64'd0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("mr_no_redecode", busy, 1'b0);
      csb = 1'b1;
      repeat (16) @(negedge clk);
      clear_sb();
      tx_bytes[0] = 8'h96;
      spi_xfer(16'h0042, 8, 1'b0);
      chk("mr_wr_count", wr_addr_q.size(), 1);
      chk("mr_wr_addr", wr_addr_q[0], 13'h042);
      chk("mr_wr_data", wr_data_q[0], 8'h96);

      chk("wr_rd_exclusive", overlap, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
- SPI slave protocol engine for the AD9467-style 3/4-wire control port; sits directly upstream of spi_encoder.
- Oversamples SCLK/CSB/SDI in the system clock domain and decodes the 16-bit instruction plus data phase.
- Issues register-bank read/write strobes and drives spi_encoder's I_enable, I_latch and I_data for readback.
- Protocol: MSB first. Instruction is R/W(1=read), W1:W0, A12:A0, followed by data bytes; the address decrements per byte.

Parameters:
- ADDR_W, 13: register address width (instruction field width).
- DATA_W, 8: register/data byte width; must equal spi_encoder DATA_SIZE.
- SYNC_STAGES, 2: synchronizer depth on I_sclk_pin, I_csb_pin and I_sdi_pin (≥2).

Ports:
- I_clk  in  1  system clock, ≥8× SCLK frequency
- I_rst  in  1  synchronous reset, active-high
- I_sclk_pin  in  1  SPI clock (asynchronous)
- I_csb_pin  in  1  SPI chip select, active-low (asynchronous)
- I_sdi_pin  in  1  SPI serial data in (asynchronous)
- I_reg_rdata  in  DATA_W  register read data, valid the cycle after O_reg_rd
- O_reg_addr  out  ADDR_W  current register address
- O_reg_wdata  out  DATA_W  write data, valid with O_reg_wr
- O_reg_wr  out  1  one-cycle write strobe
- O_reg_rd  out  1  one-cycle read strobe
- O_enc_enable  out  1  to spi_encoder I_enable
- O_enc_latch  out  1  to spi_encoder I_latch
- O_enc_data  out  DATA_W  to spi_encoder I_data
- O_busy  out  1  high while a transaction is in progress (state ≠ IDLE)

Behaviour:
- Single clock I_clk; reset is synchronous, active-high. On reset all outputs are 0, the state is IDLE, counters are 0 and the synchronizers are loaded with 1 (CSB and SCLK idle high).
- Edge detect on the synchronized SCLK: rise = sync 0→1; fall = sync 1→0. Each detection is a one-cycle pulse. SDI is sampled on the rise pulse.
- CSB falling (synchronized) in IDLE → INSTR; bit_cnt=0.
- INSTR: shift SDI on each rise. On the 16th rise, capture rw, W and addr, then:
  - byte_left = W (W=3 means streaming).
  - O_reg_addr = addr.
  - rw=0 → WR.
  - rw=1 → RD, with O_reg_rd pulsed on the next cycle.
- WR: shift 8 bits. On the 8th rise, pulse O_reg_wr for one cycle with O_reg_wdata and the current O_reg_addr. The address decrements the cycle after the strobe.
  - If W≠3 and byte_left==0 → DONE; otherwise byte_left decrements.
- RD:
  - The cycle after O_reg_rd: O_enc_data = I_reg_rdata, O_enc_latch=1, O_enc_enable=1.
  - O_enc_latch clears on the cycle after the next fall pulse. The encoder loads on that real SCLK falling edge.
  - Count 8 rises per byte. On the 8th rise: decrement the address, pulse O_reg_rd, then re-latch as above.
  - When the count is exhausted (W≠3), go to DONE with no further O_reg_rd. O_enc_enable stays 1 until CSB rises.
- DONE: ignore SCLK/SDI until CSB rises.
- CSB rising in any state → IDLE within 1 cycle of detection:
  - O_enc_enable=0, O_enc_latch=0, byte/bit counters cleared.
  - A partial byte (<8 bits) generates no write.
- Address wrap: 0 decrements to 2^ADDR_W−1.
- A rise pulse and CSB rise in the same cycle: CSB has priority; the bit is discarded.
- O_reg_wr and O_reg_rd are never high in the same cycle.
- Reset mid-transaction: immediate IDLE. The CSB high→low sequence must be seen again before a new transaction is decoded.
- Latency: O_reg_wr comes SYNC_STAGES+2 I_clk cycles after the 8th real SCLK rising edge, worst case.

Test Plan:
- Write 1 byte: instr 0x0014 (rw=0, W=0, addr=0x014), data 0xA5 → one O_reg_wr, addr=0x014, wdata=0xA5; O_busy drops after CSB high.
- Write 3 bytes: W=2, addr=0x0FF, data 0x11,0x22,0x33 → O_reg_wr at 0x0FF/0x11, 0x0FE/0x22, 0x0FD/0x33; extra clocked bytes ignored.
- Read 2 bytes: instr 0xA005 (rw=1, W=1, addr=0x005) with rdata model addr5=0x3C, addr4=0xC3 → O_reg_rd at 5 then 4. Encoder model SDO shifts 0x3C then 0xC3 MSB first on the data-phase falling edges.
- Streaming write W=3 starting at addr 0x001, 4 bytes → writes at 0x001, 0x000, 0x1FFF, 0x1FFE (wrap).
- Abort: CSB rises after 5 data bits of a write → no O_reg_wr, state IDLE, O_enc_enable=0; the next transaction decodes correctly.
- I_rst asserted mid-read → all outputs 0 next cycle. A fresh write transaction afterwards completes normally.
